conv_acc_q: RTL and testbench
=============================

Name: conv_acc_q

Overview:
- Next-generation 3x3-conv partial-sum accumulator for the systolic-array datapath.
- Takes one DN-lane row per cycle from the array result buffer and adds bias (first kernel tap) or the running partial sum (other taps).
- Writes intermediate sums back to the accumulation buffer; on the last tap, emits requantized, saturated, optionally ReLU'd results to the scale path.
- Adds over the previous generation: a queued command interface with backpressure, configurable memory read latency, signed arithmetic, requantization, a done pulse and write addresses.

Parameters:
- AW, 11, address width of all buffers
- DW, 22, accumulator lane width (signed)
- DN, 6, lanes per word
- OW, 8, requantized output lane width (signed)
- SW, 8, width of the command size field
- RD_LAT, 1, read latency of the source buffers in cycles (>=1)
- CQ, 2, command queue depth (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept
- cmd_base1  in  AW  array-result read base
- cmd_base2  in  AW  bias/acc read base, also write base
- cmd_size  in  SW  words in command
- cmd_first_k  in  1  add bias (1) or partial sum (0)
- cmd_last_k  in  1  final tap: route to scale output
- cmd_shift  in  5  requant right-shift amount
- cmd_relu  in  1  clamp negatives to 0 on the s path
- rd_en  out  1  read strobe for all three buffers
- m_addr1  out  AW  array-result address
- m_addr2  out  AW  bias address
- m_addr3  out  AW  partial-sum address (equal to m_addr2)
- m_data1  in  DW*DN  array result
- m_data2  in  DW*DN  bias
- m_data3  in  DW*DN  partial sum
- m_sum  out  DW*DN  partial sum to write back
- m_valid  out  1  m_sum write enable
- m_waddr  out  AW  write address for m_sum
- s_sum  out  OW*DN  requantized result
- s_valid  out  1  s_sum write enable
- s_waddr  out  AW  write address for s_sum
- done  out  1  one-cycle pulse with the last output word of a command
- busy  out  1  queue non-empty, sequencer running or data in flight

Behaviour:
- Reset: all outputs 0; queue empty; sequencer IDLE; in-flight pipeline discarded (no valids emitted after reset).
- Command queue: CQ-entry FIFO. Push when cmd_valid && cmd_ready. cmd_ready = !full, combinational on registered count; a pop in the same cycle does not lift cmd_ready. Commands with size 0 are popped and dropped: no reads, no done.
- Sequencer states:
  - IDLE: if queue is non-empty, pop and go to RUN.
  - RUN: issue one read per cycle for size cycles. Word i uses addr1 = base1+i and addr2 = addr3 = base2+i; addresses wrap mod 2^AW. On the last read, if the queue is non-empty, pop and continue RUN with no bubble; otherwise go to IDLE.
- Sideband: first_k, last_k, shift, relu, write address (base2+i) and a last-word flag travel in an RD_LAT-deep shift register aligned to the returning data.
- Arithmetic, per lane, signed two's complement: sum = m_data1 + (first ? m_data2 : m_data3), wrapping at DW bits.
- Output register: result appears RD_LAT+1 cycles after its rd_en.
  - last_k=0: m_valid=1, m_sum=sum, m_waddr=addr.
  - last_k=1: s_valid=1, s_waddr=addr, m_valid=0. m_sum still carries the raw sum.
- Requant, per lane, computed in DW+1 bits:
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift (round half up).
  - If relu and r<0, r = 0.
  - Saturate r to [-2^(OW-1), 2^(OW-1)-1].
- done asserts in the same cycle as the valid of each command's final word.
- Back-to-back commands with different first_k/last_k switch exactly at the word boundary.

Test Plan:
- Reset, then cmd size=4, base1=0x010, base2=0x100, first_k=1, last_k=0, RD_LAT=1 -> rd_en high 4 cycles, addr1 0x010..0x013; m_valid cycles 3..6 with m_sum = data1+bias, m_waddr 0x100..0x103; done with the 4th word.
- Two queued cmds (size 3 first_k=1, then size 2 first_k=0 last_k=1) -> 5 consecutive rd_en; words 1-3 on m_valid, words 4-5 on s_valid; two done pulses.
- last_k=1, shift=4, relu=0, lane sum=0x000028 (40) -> 3; sum=-40 -> -2; sum=5000 -> 127; sum=-5000 -> -128; relu=1 with -40 -> 0.
- Push 3 cmds with CQ=2 while the first runs -> cmd_ready low when full; third accepted after a pop; no command lost; busy high until the last done.
- base2=0x7FE, size=4 -> write addresses 0x7FE, 0x7FF, 0x000, 0x001; RD_LAT=3 build -> valid 4 cycles after rd_en.
- Assert rst mid-command -> next cycle all valids, rd_en, busy 0; following new cmd runs from a clean state; size=0 cmd -> no rd_en, no done.

Source files
------------

// File: rtl/conv_acc_q.sv
// conv_acc_q: queued 3x3-conv partial-sum accumulator with requantized, saturated output path
module conv_acc_q #(
  parameter int AW     = 11,
  parameter int DW     = 22,
  parameter int DN     = 6,
  parameter int OW     = 8,
  parameter int SW     = 8,
  parameter int RD_LAT = 1,
  parameter int CQ     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_base1,
  input  logic [AW-1:0]    cmd_base2,
  input  logic [SW-1:0]    cmd_size,
  input  logic             cmd_first_k,
  input  logic             cmd_last_k,
  input  logic [4:0]       cmd_shift,
  input  logic             cmd_relu,
  output logic             rd_en,
  output logic [AW-1:0]    m_addr1,
  output logic [AW-1:0]    m_addr2,
  output logic [AW-1:0]    m_addr3,
  input  logic [DW*DN-1:0] m_data1,
  input  logic [DW*DN-1:0] m_data2,
  input  logic [DW*DN-1:0] m_data3,
  output logic [DW*DN-1:0] m_sum,
  output logic             m_valid,
  output logic [AW-1:0]    m_waddr,
  output logic [OW*DN-1:0] s_sum,
  output logic             s_valid,
  output logic [AW-1:0]    s_waddr,
  output logic             done,
  output logic             busy
);
  localparam int QW = (CQ > 1) ? $clog2(CQ) : 1;
  localparam logic signed [DW:0] PMAX = (DW+1)'(2**(OW-1)-1);
  localparam logic signed [DW:0] NMIN = (DW+1)'(-(2**(OW-1)));
  typedef struct packed {
    logic [AW-1:0] b1;
    logic [AW-1:0] b2;
    logic [SW-1:0] sz;
    logic          fk;
    logic          lk;
    logic [4:0]    sh;
    logic          rl;
  } cmd_t;
  typedef struct packed {
    logic          v;
    logic          fk;
    logic          lk;
    logic          rl;
    logic          lw;
    logic [4:0]    sh;
    logic [AW-1:0] a;
  } sb_t;
  typedef enum logic {IDLE, RUN} state_t;
  cmd_t             q_q [CQ];
  cmd_t             q_d [CQ];
  cmd_t             cur_q, cur_d, head;
  logic [QW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [QW:0]      cnt_q, cnt_d;
  state_t           st_q, st_d;
  logic [SW-1:0]    idx_q, idx_d;
  logic             push, pop, last_rd, in_flight;
  sb_t              sb_q [RD_LAT];
  sb_t              sb_d [RD_LAT];
  sb_t              tl;
  logic [DW*DN-1:0] m_sum_q, m_sum_d;
  logic [OW*DN-1:0] s_sum_q, s_sum_d;
  logic [AW-1:0]    m_waddr_q, m_waddr_d, s_waddr_q, s_waddr_d;
  logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d, done_q, done_d;

  // round half up, optional ReLU, then saturate to the signed output range
  function automatic logic [OW-1:0] requant(input logic signed [DW-1:0] s, input logic [4:0] sh, input logic rl);
    logic signed [DW:0] e, k, r;
    e = (DW+1)'(s);
    k = sh != 5'd0 ? (DW+1)'(1) << (sh - 5'd1) : '0;
    r = (e + k) >>> sh;
    r = (rl && r < 0) ? '0 : r;
    return r > PMAX ? PMAX[OW-1:0] : r < NMIN ? NMIN[OW-1:0] : r[OW-1:0];
  endfunction

  assign head      = q_q[rp_q];
  assign cmd_ready = cnt_q != (QW+1)'(CQ);
  assign push      = cmd_valid && cmd_ready;
  assign rd_en     = st_q == RUN;
  assign last_rd   = rd_en && idx_q == cur_q.sz - SW'(1);
  assign m_addr1   = cur_q.b1 + AW'(idx_q);
  assign m_addr2   = cur_q.b2 + AW'(idx_q);
  assign m_addr3   = m_addr2;
  assign tl        = sb_q[RD_LAT-1];
  assign m_sum     = m_sum_q;
  assign m_valid   = m_valid_q;
  assign m_waddr   = m_waddr_q;
  assign s_sum     = s_sum_q;
  assign s_valid   = s_valid_q;
  assign s_waddr   = s_waddr_q;
  assign done      = done_q;
  assign busy      = cnt_q != '0 || rd_en || in_flight || m_valid_q || s_valid_q;

  // sequencer: pop on idle or on the last read so commands chain without a bubble; size 0 is dropped
  always_comb begin
    st_d  = st_q;
    cur_d = cur_q;
    idx_d = idx_q + SW'(rd_en);
    pop   = 1'b0;
    if ((st_q == IDLE || last_rd) && cnt_q != '0) begin
      pop   = 1'b1;
      cur_d = head;
      idx_d = '0;
      st_d  = head.sz != '0 ? RUN : IDLE;
    end else if (last_rd) st_d = IDLE;
  end

  // command FIFO bookkeeping
  always_comb begin
    q_d = q_q;
    if (push) q_d[wp_q] = '{b1: cmd_base1, b2: cmd_base2, sz: cmd_size, fk: cmd_first_k,
                            lk: cmd_last_k, sh: cmd_shift, rl: cmd_relu};
    wp_d  = wp_q + QW'(push);
    rp_d  = rp_q + QW'(pop);
    cnt_d = cnt_q + (QW+1)'(push) - (QW+1)'(pop);
  end

  // sideband delay line aligned to the buffer read latency
  always_comb begin
    sb_d[0] = '{v: rd_en, fk: cur_q.fk, lk: cur_q.lk, rl: cur_q.rl, lw: last_rd, sh: cur_q.sh, a: m_addr2};
    for (int i = 1; i < RD_LAT; i++) sb_d[i] = sb_q[i-1];
  end

  // any read still travelling through the sideband line
  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight | sb_q[i].v;
  end

  // lane-wise accumulate and requantize into the output register
  always_comb begin
    m_sum_d = m_sum_q;
    s_sum_d = s_sum_q;
    if (tl.v)
      for (int l = 0; l < DN; l++)
        m_sum_d[l*DW +: DW] = m_data1[l*DW +: DW] + (tl.fk ? m_data2[l*DW +: DW] : m_data3[l*DW +: DW]);
    if (tl.v && tl.lk)
      for (int l = 0; l < DN; l++) s_sum_d[l*OW +: OW] = requant(m_sum_d[l*DW +: DW], tl.sh, tl.rl);
    m_valid_d = tl.v && !tl.lk;
    s_valid_d = tl.v && tl.lk;
    done_d    = tl.v && tl.lw;
    m_waddr_d = m_valid_d ? tl.a : m_waddr_q;
    s_waddr_d = s_valid_d ? tl.a : s_waddr_q;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '{default: '0};
      cur_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      st_q      <= IDLE;
      idx_q     <= '0;
      sb_q      <= '{default: '0};
      m_sum_q   <= '0;
      s_sum_q   <= '0;
      m_waddr_q <= '0;
      s_waddr_q <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      q_q       <= q_d;
      cur_q     <= cur_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      st_q      <= st_d;
      idx_q     <= idx_d;
      sb_q      <= sb_d;
      m_sum_q   <= m_sum_d;
      s_sum_q   <= s_sum_d;
      m_waddr_q <= m_waddr_d;
      s_waddr_q <= s_waddr_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_conv_acc_q.sv
// tb_conv_acc_q: directed self-checking bench for conv_acc_q (RD_LAT=1 main instance, RD_LAT=3 latency instance)
module tb_conv_acc_q;
  localparam int AW = 11, DW = 22, DN = 6, OW = 8, SW = 8, WW = DW*DN;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic cmd_valid = 1'b0, cmd_first_k = 1'b0, cmd_last_k = 1'b0, cmd_relu = 1'b0;
  logic [AW-1:0] cmd_base1 = '0, cmd_base2 = '0;
  logic [SW-1:0] cmd_size = '0;
  logic [4:0] cmd_shift = '0;
  logic cmd_ready, rd_en, m_valid, s_valid, done, busy;
  logic [AW-1:0] m_addr1, m_addr2, m_addr3, m_waddr, s_waddr;
  logic [WW-1:0] d1, d2, d3, m_sum;
  logic [OW*DN-1:0] s_sum;
  logic x_ready, x_rd_en, x_m_valid, x_s_valid, x_done, x_busy;
  logic [AW-1:0] x_addr1, x_addr2, x_addr3, x_m_waddr, x_s_waddr;
  logic [WW-1:0] p1 [3], p2 [3], p3 [3], x_m_sum;
  logic [OW*DN-1:0] x_s_sum;
  logic [WW-1:0] mem1 [2**AW], mem2 [2**AW], mem3 [2**AW];
  int cyc = 0, checks = 0, errors = 0;
  int rd_c[$], mv_c[$], sv_c[$], dn_c[$], bz_lo[$], r3_c[$], v3_c[$];
  logic [AW-1:0] a1_q[$], a2_q[$], a3_q[$], mv_a[$], sv_a[$];
  logic [WW-1:0] mv_s[$], sv_r[$], v3_s[$];
  logic [OW*DN-1:0] sv_s[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_acc_q #(.RD_LAT(1)) u (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base1(cmd_base1),
    .cmd_base2(cmd_base2), .cmd_size(cmd_size), .cmd_first_k(cmd_first_k), .cmd_last_k(cmd_last_k),
    .cmd_shift(cmd_shift), .cmd_relu(cmd_relu), .rd_en(rd_en), .m_addr1(m_addr1), .m_addr2(m_addr2),
    .m_addr3(m_addr3), .m_data1(d1), .m_data2(d2), .m_data3(d3), .m_sum(m_sum), .m_valid(m_valid),
    .m_waddr(m_waddr), .s_sum(s_sum), .s_valid(s_valid), .s_waddr(s_waddr), .done(done), .busy(busy));

  conv_acc_q #(.RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(x_ready), .cmd_base1(cmd_base1),
    .cmd_base2(cmd_base2), .cmd_size(cmd_size), .cmd_first_k(cmd_first_k), .cmd_last_k(cmd_last_k),
    .cmd_shift(cmd_shift), .cmd_relu(cmd_relu), .rd_en(x_rd_en), .m_addr1(x_addr1), .m_addr2(x_addr2),
    .m_addr3(x_addr3), .m_data1(p1[2]), .m_data2(p2[2]), .m_data3(p3[2]), .m_sum(x_m_sum),
    .m_valid(x_m_valid), .m_waddr(x_m_waddr), .s_sum(x_s_sum), .s_valid(x_s_valid), .s_waddr(x_s_waddr),
    .done(x_done), .busy(x_busy));

  always @(posedge clk) begin
    d1 <= mem1[m_addr1];
    d2 <= mem2[m_addr2];
    d3 <= mem3[m_addr3];
  end

  always @(posedge clk) begin
    p1[0] <= mem1[x_addr1]; p1[1] <= p1[0]; p1[2] <= p1[1];
    p2[0] <= mem2[x_addr2]; p2[1] <= p2[0]; p2[2] <= p2[1];
    p3[0] <= mem3[x_addr3]; p3[1] <= p3[0]; p3[2] <= p3[1];
  end

  always @(posedge clk) begin
    #1;
    if (clr) begin
      rd_c.delete(); mv_c.delete(); sv_c.delete(); dn_c.delete(); bz_lo.delete(); r3_c.delete(); v3_c.delete();
      a1_q.delete(); a2_q.delete(); a3_q.delete(); mv_a.delete(); sv_a.delete(); mv_s.delete(); sv_r.delete();
      v3_s.delete(); sv_s.delete();
    end
    if (rd_en) begin rd_c.push_back(cyc); a1_q.push_back(m_addr1); a2_q.push_back(m_addr2); a3_q.push_back(m_addr3); end
    if (m_valid) begin mv_c.push_back(cyc); mv_a.push_back(m_waddr); mv_s.push_back(m_sum); end
    if (s_valid) begin sv_c.push_back(cyc); sv_a.push_back(s_waddr); sv_s.push_back(s_sum); sv_r.push_back(m_sum); end
    if (done) dn_c.push_back(cyc);
    if (!busy) bz_lo.push_back(cyc);
    if (x_rd_en) r3_c.push_back(cyc);
    if (x_m_valid || x_s_valid) begin v3_c.push_back(cyc); v3_s.push_back(x_m_sum); end
  end

  function automatic logic [WW-1:0] exp_sum(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic fk);
    logic [WW-1:0] x, y, r;
    x = mem1[a1];
    y = fk ? mem2[a2] : mem3[a2];
    r = '0;
    for (int l = 0; l < DN; l++) r[l*DW +: DW] = x[l*DW +: DW] + y[l*DW +: DW];
    return r;
  endfunction

  task automatic clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic send(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input logic [SW-1:0] sz,
                      input logic fk, input logic lk, input logic [4:0] sh, input logic rl);
    int n = 0;
    cmd_base1 = b1; cmd_base2 = b2; cmd_size = sz; cmd_first_k = fk; cmd_last_k = lk;
    cmd_shift = sh; cmd_relu = rl; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL send_accept: cmd_ready=%b after %0d cycles, need 1", cmd_ready, n); end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b after %0d cycles, need 0", busy, n); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b need 0", rd_en); end
    checks++; if (m_valid !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL reset_valids: got m=%b s=%b need 0", m_valid, s_valid); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy: got done=%b busy=%b need 0", done, busy); end
    checks++; if (m_sum !== '0 || s_sum !== '0 || m_waddr !== '0 || s_waddr !== '0) begin errors++; $display("FAIL reset_data: got m_sum=%h s_sum=%h need 0", m_sum, s_sum); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", cmd_ready); end
  endtask

  task automatic test_single();
    logic [WW-1:0] t;
    clear();
    send(11'h010, 11'h100, 4, 1, 0, 0, 0);
    wait_idle();
    checks++; if (rd_c.size() != 4) begin errors++; $display("FAIL single_rd_count: got %0d need 4", rd_c.size()); end
    if (rd_c.size() == 4)
      for (int i = 0; i < 4; i++) begin
        checks++; if (a1_q[i] !== AW'(11'h010 + i) || a2_q[i] !== AW'(11'h100 + i) || a3_q[i] !== AW'(11'h100 + i)) begin errors++; $display("FAIL single_addr%0d: got %h/%h/%h need %h/%h", i, a1_q[i], a2_q[i], a3_q[i], 11'h010 + i, 11'h100 + i); end
      end
    checks++; if (mv_c.size() != 4) begin errors++; $display("FAIL single_mv_count: got %0d need 4", mv_c.size()); end
    if (mv_c.size() == 4 && rd_c.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (mv_c[i] - rd_c[i] != 2) begin errors++; $display("FAIL single_latency%0d: got %0d need 2", i, mv_c[i] - rd_c[i]); end
        checks++; if (mv_a[i] !== AW'(11'h100 + i)) begin errors++; $display("FAIL single_waddr%0d: got %h need %h", i, mv_a[i], 11'h100 + i); end
        checks++; if (mv_s[i] !== exp_sum(AW'(11'h010 + i), AW'(11'h100 + i), 1'b1)) begin errors++; $display("FAIL single_sum%0d: got %h need %h", i, mv_s[i], exp_sum(AW'(11'h010 + i), AW'(11'h100 + i), 1'b1)); end
      end
      t = mv_s[0];
      checks++; if (t[DW-1:0] !== 22'h3FFF10) begin errors++; $display("FAIL single_lane0: got %h need 3fff10", t[DW-1:0]); end
      checks++; if (dn_c.size() != 1 || dn_c[0] != mv_c[3]) begin errors++; $display("FAIL single_done: got %0d pulses, need 1 at cycle %0d", dn_c.size(), mv_c[3]); end
    end
    checks++; if (sv_c.size() != 0) begin errors++; $display("FAIL single_no_s: got %0d s words need 0", sv_c.size()); end
  endtask

  task automatic test_back_to_back();
    clear();
    send(11'h020, 11'h120, 3, 1, 0, 0, 0);
    send(11'h030, 11'h140, 2, 0, 1, 0, 0);
    wait_idle();
    checks++; if (rd_c.size() != 5 || rd_c[4] - rd_c[0] != 4) begin errors++; $display("FAIL b2b_rd: got %0d reads, need 5 consecutive", rd_c.size()); end
    checks++; if (mv_c.size() != 3 || sv_c.size() != 2) begin errors++; $display("FAIL b2b_split: got m=%0d s=%0d need 3/2", mv_c.size(), sv_c.size()); end
    if (mv_c.size() == 3 && sv_c.size() == 2) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (mv_s[i] !== exp_sum(AW'(11'h020 + i), AW'(11'h120 + i), 1'b1)) begin errors++; $display("FAIL b2b_msum%0d: got %h", i, mv_s[i]); end
      end
      for (int i = 0; i < 2; i++) begin
        checks++; if (sv_s[i] !== {DN{8'h7F}} || sv_a[i] !== AW'(11'h140 + i)) begin errors++; $display("FAIL b2b_s%0d: got %h @%h need %h @%h", i, sv_s[i], sv_a[i], {DN{8'h7F}}, 11'h140 + i); end
        checks++; if (sv_r[i] !== exp_sum(AW'(11'h030 + i), AW'(11'h140 + i), 1'b0)) begin errors++; $display("FAIL b2b_raw%0d: got %h", i, sv_r[i]); end
      end
      checks++; if (sv_c[0] != mv_c[2] + 1) begin errors++; $display("FAIL b2b_boundary: s at %0d need %0d", sv_c[0], mv_c[2] + 1); end
      checks++; if (dn_c.size() != 2 || dn_c[0] != mv_c[2] || dn_c[1] != sv_c[1]) begin errors++; $display("FAIL b2b_done: got %0d pulses need 2 at %0d,%0d", dn_c.size(), mv_c[2], sv_c[1]); end
    end
  endtask

  task automatic test_requant();
    int vals [6] = '{40, -40, 5000, -5000, 8, 7};
    logic [WW-1:0] t;
    for (int l = 0; l < DN; l++) t[l*DW +: DW] = DW'(vals[l]);
    mem1[11'h200] = t;
    mem2[11'h300] = '0;
    clear();
    send(11'h200, 11'h300, 1, 1, 1, 4, 0);
    send(11'h200, 11'h300, 1, 1, 1, 4, 1);
    wait_idle();
    checks++; if (mv_c.size() != 0 || sv_c.size() != 2) begin errors++; $display("FAIL rq_counts: got m=%0d s=%0d need 0/2", mv_c.size(), sv_c.size()); end
    if (sv_c.size() == 2) begin
      checks++; if (sv_s[0] !== 48'h0001807FFE03) begin errors++; $display("FAIL rq_plain: got %h need 0001807ffe03", sv_s[0]); end
      checks++; if (sv_s[1] !== 48'h0001007F0003) begin errors++; $display("FAIL rq_relu: got %h need 0001007f0003", sv_s[1]); end
      checks++; if (sv_r[0] !== t || sv_a[0] !== 11'h300) begin errors++; $display("FAIL rq_raw: got %h @%h need %h @300", sv_r[0], sv_a[0], t); end
    end
    checks++; if (dn_c.size() != 2) begin errors++; $display("FAIL rq_done: got %0d need 2", dn_c.size()); end
  endtask

  task automatic test_queue_full();
    logic [AW-1:0] eb1 [4] = '{11'h040, 11'h0A0, 11'h0B0, 11'h0C0};
    logic [AW-1:0] eb2 [4] = '{11'h180, 11'h190, 11'h1A0, 11'h1B0};
    int esz [4] = '{6, 2, 2, 2};
    int k = 0, gap = 0;
    clear();
    send(eb1[0], eb2[0], 6, 1, 0, 0, 0);
    send(eb1[1], eb2[1], 2, 1, 0, 0, 0);
    send(eb1[2], eb2[2], 2, 1, 0, 0, 0);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL qf_ready_low: got %b need 0", cmd_ready); end
    send(eb1[3], eb2[3], 2, 1, 0, 0, 0);
    wait_idle();
    checks++; if (mv_c.size() != 12 || dn_c.size() != 4) begin errors++; $display("FAIL qf_counts: got %0d words %0d done need 12/4", mv_c.size(), dn_c.size()); end
    if (mv_c.size() == 12 && dn_c.size() == 4) begin
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < esz[c]; i++) begin
          checks++; if (mv_a[k] !== AW'(eb2[c] + i) || mv_s[k] !== exp_sum(AW'(eb1[c] + i), AW'(eb2[c] + i), 1'b1)) begin errors++; $display("FAIL qf_word%0d: got %h @%h need @%h", k, mv_s[k], mv_a[k], eb2[c] + i); end
          k++;
        end
      foreach (bz_lo[j]) if (bz_lo[j] >= rd_c[0] && bz_lo[j] <= dn_c[3]) gap++;
      checks++; if (gap != 0) begin errors++; $display("FAIL qf_busy: busy low %0d cycles while active, need 0", gap); end
    end
  endtask

  task automatic test_wrap_lat3();
    logic [AW-1:0] wa [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    clear();
    send(11'h050, 11'h7FE, 4, 0, 0, 0, 0);
    wait_idle();
    checks++; if (mv_c.size() != 4 || r3_c.size() != 4 || v3_c.size() != 4) begin errors++; $display("FAIL wrap_counts: got %0d/%0d/%0d need 4", mv_c.size(), r3_c.size(), v3_c.size()); end
    if (mv_c.size() == 4 && r3_c.size() == 4 && v3_c.size() == 4)
      for (int i = 0; i < 4; i++) begin
        checks++; if (mv_a[i] !== wa[i]) begin errors++; $display("FAIL wrap_waddr%0d: got %h need %h", i, mv_a[i], wa[i]); end
        checks++; if (mv_s[i] !== exp_sum(AW'(11'h050 + i), wa[i], 1'b0)) begin errors++; $display("FAIL wrap_sum%0d: got %h", i, mv_s[i]); end
        checks++; if (v3_c[i] - r3_c[i] != 4) begin errors++; $display("FAIL lat3_latency%0d: got %0d need 4", i, v3_c[i] - r3_c[i]); end
        checks++; if (v3_s[i] !== exp_sum(AW'(11'h050 + i), wa[i], 1'b0)) begin errors++; $display("FAIL lat3_sum%0d: got %h", i, v3_s[i]); end
      end
  endtask

  task automatic test_reset_mid();
    clear();
    send(11'h070, 11'h1D0, 20, 1, 0, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rd_en !== 1'b0 || m_valid !== 1'b0 || s_valid !== 1'b0 || busy !== 1'b0 || x_busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got rd=%b mv=%b sv=%b busy=%b/%b need 0", rd_en, m_valid, s_valid, busy, x_busy); end
    rst = 1'b0;
    clear();
    repeat (6) @(negedge clk);
    checks++; if (rd_c.size() != 0 || mv_c.size() != 0 || sv_c.size() != 0 || v3_c.size() != 0) begin errors++; $display("FAIL rstmid_flushed: got rd=%0d mv=%0d sv=%0d v3=%0d need 0", rd_c.size(), mv_c.size(), sv_c.size(), v3_c.size()); end
    clear();
    send(11'h080, 11'h1E0, 2, 0, 0, 0, 0);
    wait_idle();
    checks++; if (mv_c.size() != 2 || dn_c.size() != 1) begin errors++; $display("FAIL rstmid_after: got %0d words %0d done need 2/1", mv_c.size(), dn_c.size()); end
    if (mv_c.size() == 2)
      for (int i = 0; i < 2; i++) begin
        checks++; if (mv_a[i] !== AW'(11'h1E0 + i) || mv_s[i] !== exp_sum(AW'(11'h080 + i), AW'(11'h1E0 + i), 1'b0)) begin errors++; $display("FAIL rstmid_word%0d: got %h @%h", i, mv_s[i], mv_a[i]); end
      end
  endtask

  task automatic test_size_zero();
    clear();
    send(11'h090, 11'h1F0, 0, 1, 0, 0, 0);
    repeat (8) @(negedge clk);
    checks++; if (rd_c.size() != 0 || dn_c.size() != 0 || mv_c.size() != 0) begin errors++; $display("FAIL size0: got rd=%0d done=%0d mv=%0d need 0", rd_c.size(), dn_c.size(), mv_c.size()); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL size0_idle: got busy=%b ready=%b need 0/1", busy, cmd_ready); end
  endtask

  initial begin
    logic [WW-1:0] t1, t2, t3;
    for (int a = 0; a < 2**AW; a++) begin
      for (int l = 0; l < DN; l++) begin
        t1[l*DW +: DW] = DW'(a + (l << 12));
        t2[l*DW +: DW] = DW'(l - 256);
        t3[l*DW +: DW] = DW'(a * 3 + l);
      end
      mem1[a] = t1; mem2[a] = t2; mem3[a] = t3;
    end
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_requant();
    test_queue_full();
    test_wrap_lat3();
    test_reset_mid();
    test_size_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
